// File: rtl/sdp_fifo_pkg.sv
// Shared types and width helpers for the single-clock FWFT FIFO controller.
// Optional almost-full output is enabled by defining SDP_FIFO_ALMOST_EN.
package sdp_fifo_pkg;

  // Encoding is {write_accept, read_issue} so the enum can be cast directly.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    POP      = 2'b01,
    PUSH     = 2'b10,
    PUSH_POP = 2'b11
  } flow_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/ram_sdp_one_clock.sv
// Simple dual-port RAM, one clock: port A writes, port B reads into an output
// register that only updates when enb is high. Contents are never cleared.
module ram_sdp_one_clock
  import sdp_fifo_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32
) (
  input  logic                         clk,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [addr_width(DEPTH)-1:0] addra,
  input  logic [DWIDTH-1:0]            dia,
  input  logic                         enb,
  input  logic [addr_width(DEPTH)-1:0] addrb,
  output logic [DWIDTH-1:0]            dob
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
  end

  always_ff @(posedge clk) begin
    if (enb) dob <= mem[addrb];
  end

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through FIFO built on ram_sdp_one_clock; the RAM output
// register is the head stage. Define SDP_FIFO_ALMOST_EN to get almost_full.
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32
`ifdef SDP_FIFO_ALMOST_EN
  , parameter int AF_LEVEL = DEPTH - 4
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DWIDTH-1:0]           wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DWIDTH-1:0]           rd_data,
  output logic [cnt_width(DEPTH)-1:0] count
`ifdef SDP_FIFO_ALMOST_EN
  , output logic                      almost_full
`endif
);

  localparam int AWIDTH = addr_width(DEPTH);
  localparam int CWIDTH = cnt_width(DEPTH);

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [CWIDTH-1:0] ram_cnt;
  logic [CWIDTH-1:0] ram_cnt_nxt;
  logic [CWIDTH-1:0] count_nxt;
  logic              head_vld;
  logic              head_nxt;
  logic              wr_accept;
  logic              issue;
  logic              pop;
  flow_t             flow;

  assign wr_ready  = rst_n && (ram_cnt != CWIDTH'(DEPTH));
  assign wr_accept = wr_valid && wr_ready;
  assign rd_valid  = rst_n && head_vld;
  assign pop       = rd_valid && rd_ready;
  // Reading only with ram_cnt != 0 keeps rd_ptr away from wr_ptr on any write.
  assign issue     = rst_n && (ram_cnt != '0) && (!head_vld || rd_ready);
  assign flow      = flow_t'({wr_accept, issue});

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    case (flow)
      PUSH:    ram_cnt_nxt = ram_cnt + CWIDTH'(1);
      POP:     ram_cnt_nxt = ram_cnt - CWIDTH'(1);
      default: ram_cnt_nxt = ram_cnt;
    endcase
    head_nxt = head_vld;
    if (issue)    head_nxt = 1'b1;
    else if (pop) head_nxt = 1'b0;
    count_nxt = ram_cnt_nxt + CWIDTH'(head_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      head_vld <= 1'b0;
      count    <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (issue)     rd_ptr <= rd_ptr + AWIDTH'(1);
      ram_cnt  <= ram_cnt_nxt;
      head_vld <= head_nxt;
      count    <= count_nxt;
    end
  end

`ifdef SDP_FIFO_ALMOST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (count_nxt >= CWIDTH'(AF_LEVEL));
  end
`endif

  ram_sdp_one_clock #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .ena   (wr_accept),
    .wea   (wr_accept),
    .addra (wr_ptr),
    .dia   (wr_data),
    .enb   (issue),
    .addrb (rd_ptr),
    .dob   (rd_data)
  );

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Scoreboard bench for sdp_fifo_ctrl; checks almost_full too when
// SDP_FIFO_ALMOST_EN is defined.
module tb_sdp_fifo_ctrl;

  localparam int DWIDTH   = 64;
  localparam int DEPTH    = 32;
  localparam int CW       = $clog2(DEPTH + 2);
  localparam int AF_LEVEL = DEPTH - 4;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DWIDTH-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DWIDTH-1:0] rd_data;
  logic [CW-1:0]     count;
`ifdef SDP_FIFO_ALMOST_EN
  logic              almost_full;
`endif

  entry_t      sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        exp_wr_ready = 1'b0;
  logic        exp_valid;
  logic [63:0] next_data = '0;

  sdp_fifo_ctrl #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count)
`ifdef SDP_FIFO_ALMOST_EN
    , .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; the word enters the scoreboard only if the
  // model says the FIFO has room this cycle.
  task automatic applyStimulus(input logic rst, input logic wv, input logic [63:0] d, input logic rr);
    @(negedge clk);
    rst_n    = rst;
    wr_valid = wv;
    wr_data  = d;
    rd_ready = rr;
    #2;
    if (wv && exp_wr_ready) begin
      sb.push_back('{d, cyc});
      next_data = next_data + 64'd1;
    end
  endtask

  // Model: a word accepted in cycle k is visible from cycle k+2 once it is at
  // the front; capacity is DEPTH+1 words.
  always @(negedge clk) begin
    #1;
    exp_wr_ready = rst_n && (sb.size() != DEPTH + 1);
    if (cyc != 0) begin
      exp_valid = rst_n && (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
      checkOutput("count", 64'(count), 64'(sb.size()));
      checkOutput("wr_ready", 64'(wr_ready), 64'(exp_wr_ready));
      checkOutput("rd_valid", 64'(rd_valid), 64'(exp_valid));
`ifdef SDP_FIFO_ALMOST_EN
      checkOutput("almost_full", 64'(almost_full), 64'(sb.size() >= AF_LEVEL));
`endif
      if (exp_valid) checkOutput("rd_data", rd_data, sb[0].data);
      if (exp_valid && rd_ready) void'(sb.pop_front());
      if (!rst_n) sb.delete();
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with a pending write, then idle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 64'hDEAD, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);

    // Single word, held at the head, then popped.
    applyStimulus(1'b1, 1'b1, 64'hA5A5, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);

    // Fill to capacity, then pop and write together at full, then drain.
    next_data = '0;
    for (int i = 0; i < 36; i++) applyStimulus(1'b1, 1'b1, next_data, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, next_data, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);

    // Sustained streaming.
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b1, next_data, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);

    // Random traffic, write-biased first half, read-biased second half.
    for (int i = 0; i < 600; i++) begin
      logic wv, rr;
      wv = ($urandom_range(0, 99) < (i < 300 ? 75 : 40));
      rr = ($urandom_range(0, 99) < (i < 300 ? 40 : 75));
      applyStimulus(1'b1, wv, {$urandom, $urandom}, rr);
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);

    // Mid-operation reset with 10 words held.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, next_data, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'hBAD, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
